// File: rtl/pixel_compositor_if.sv
// Bus between the pixel compositor, the upstream layer sources and the VGA sink.
// master = compositor side, slave = upstream/sink side.
interface pixel_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  // Handshake: a pixel is consumed on every rising edge where VGA_ready=1 and
  // sync_clear=0; layer_color/layer_mode must be valid for (pixel_x, pixel_y)
  // in that same cycle. color_valid strobes for exactly one cycle per consumed pixel.
  logic                         VGA_ready;
  logic                         sync_clear;
  logic [NUM_LAYERS*24-1:0]     layer_color;
  logic [NUM_LAYERS*2-1:0]      layer_mode;
  logic [15:0]                  pixel_x;
  logic [15:0]                  pixel_y;
  logic [18:0]                  address;
  logic [23:0]                  color;
  logic [18:0]                  color_addr;
  logic                         color_valid;
  logic                         frame_done;
  logic [7:0]                   frame_count;

  modport master (
    input  VGA_ready, sync_clear, layer_color, layer_mode,
    output pixel_x, pixel_y, address, color, color_addr, color_valid,
           frame_done, frame_count
  );

  modport slave (
    output VGA_ready, sync_clear, layer_color, layer_mode,
    input  pixel_x, pixel_y, address, color, color_addr, color_valid,
           frame_done, frame_count
  );
endinterface

// File: rtl/pixel_compositor.sv
// Raster scan generator with a priority/translucent layer compositor; one pixel
// per clock whenever the sink is ready, registered output with 1-cycle latency.
module pixel_compositor #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          NUM_LAYERS = 4,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic clk,
  input  logic rst,
  pixel_compositor_if.master bus
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [18:0] addr_q;
  logic [23:0] color_q;
  logic [18:0] color_addr_q;
  logic        color_valid_q;
  logic        frame_done_q;
  logic [7:0]  frame_count_q;

  logic [23:0] comp;
  logic [23:0] lc;
  logic [1:0]  lm;
  logic [8:0]  sum;

  // Fold from the lowest-priority layer up so layer 0 is applied last.
  always_comb begin
    comp = BG_COLOR;
    lc   = '0;
    lm   = '0;
    sum  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      lc = bus.layer_color[i*24 +: 24];
      lm = bus.layer_mode[i*2 +: 2];
      if (lc != 24'h000000 && !lm[1]) begin
        if (lm == 2'd0) begin
          comp = lc;
        end else begin
          for (int ch = 0; ch < 3; ch++) begin
            sum = {1'b0, lc[ch*8 +: 8]} + {1'b0, comp[ch*8 +: 8]};
            comp[ch*8 +: 8] = sum[8:1];
          end
        end
      end
    end
  end

  wire accept  = bus.VGA_ready && !bus.sync_clear;
  wire at_xend = (x_q == X_LAST);
  wire at_yend = (y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      color_q       <= BG_COLOR;
      color_addr_q  <= '0;
      color_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      color_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (bus.sync_clear) begin
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= '0;
      end else if (accept) begin
        color_q       <= comp;
        color_addr_q  <= addr_q;
        color_valid_q <= 1'b1;
        if (!at_xend) begin
          x_q    <= x_q + 16'd1;
          addr_q <= addr_q + 19'd1;
        end else if (!at_yend) begin
          x_q    <= '0;
          y_q    <= y_q + 16'd1;
          addr_q <= addr_q + 19'd1;
        end else begin
          x_q           <= '0;
          y_q           <= '0;
          addr_q        <= '0;
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.address     = addr_q;
  assign bus.color       = color_q;
  assign bus.color_addr  = color_addr_q;
  assign bus.color_valid = color_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 The block SHALL have the parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 The block SHALL have the parameter NUM_LAYERS, default 4, meaning the layer count; layer 0 is highest priority.
REQ-004 The block SHALL have the parameter BG_COLOR, default 24'h000000, meaning the color shown where no layer draws.
REQ-005 The block SHALL have the port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit, meaning an asynchronous, active-low reset.
REQ-007 The block SHALL have the port VGA_ready, input, 1 bit, meaning the sink accepts one pixel this cycle.
REQ-008 The block SHALL have the port sync_clear, input, 1 bit, meaning a synchronous restart of the scan to pixel (0,0).
REQ-009 The block SHALL have the port layer_color, input, NUM_LAYERS*24 bits, meaning the RGB888 color per layer for the current pixel; 24'h000000 means no draw.
REQ-010 The block SHALL have the port layer_mode, input, NUM_LAYERS*2 bits, meaning the mode per layer: 0 opaque, 1 translucent, 2 and 3 disabled.
REQ-011 The block SHALL have the port pixel_x, output, 16 bits, meaning the current scan column.
REQ-012 The block SHALL have the port pixel_y, output, 16 bits, meaning the current scan row.
REQ-013 The block SHALL have the port address, output, 19 bits, meaning the linear index of the current pixel, y*H_ACTIVE+x.
REQ-014 The block SHALL have the port color, output, 24 bits, meaning the registered composited color.
REQ-015 The block SHALL have the port color_addr, output, 19 bits, meaning the address that color belongs to.
REQ-016 The block SHALL have the port color_valid, output, 1 bit, meaning a one-cycle strobe that color/color_addr are new.
REQ-017 The block SHALL have the port frame_done, output, 1 bit, meaning a one-cycle pulse when the last pixel of a frame is accepted.
REQ-018 The block SHALL have the port frame_count, output, 8 bits, meaning the number of completed frames, modulo 256.

Function
REQ-019 Upstream logic SHALL present layer_color/layer_mode for the current (pixel_x, pixel_y) combinationally within the same cycle, and the block SHALL sample them only on cycles where VGA_ready=1.
REQ-020 The composite SHALL be formed by folding from layer NUM_LAYERS-1 down to layer 0, starting from acc=BG_COLOR; for each layer, a disabled layer or color 0 leaves acc unchanged, opaque sets acc=color, and translucent sets each channel of acc to (color_ch+acc_ch)>>1 computed in 9 bits and truncated to 8.
REQ-021 On a cycle where VGA_ready=1 and sync_clear=0, the block SHALL at the next edge load color with the composite, load color_addr with address, set color_valid=1, and advance the scan; latency is exactly 1 cycle.
REQ-022 On a cycle where VGA_ready=0, the block SHALL hold the scan position, hold color and color_addr, and drive color_valid=0.
REQ-023 Advance SHALL set x=x+1 and address=address+1 when x<H_ACTIVE-1.
REQ-024 Advance SHALL set x=0, y=y+1, and address=address+1 when x=H_ACTIVE-1 and y<V_ACTIVE-1.
REQ-025 Advance SHALL set x=0, y=0, address=0, frame_done=1 for one cycle, and frame_count=frame_count+1 (wrapping 255 to 0) when at pixel (H_ACTIVE-1, V_ACTIVE-1).
REQ-026 sync_clear=1 SHALL take priority over VGA_ready, setting x, y, and address to 0, color_valid=0, and frame_done=0, leaving color and frame_count unchanged, with no pixel consumed.
REQ-027 The scan position SHALL never exceed (H_ACTIVE-1, V_ACTIVE-1), and address SHALL never reach H_ACTIVE*V_ACTIVE.
REQ-028 Back-to-back VGA_ready=1 SHALL sustain 1 pixel per clock with no bubble, including across line and frame wrap.

Reset
REQ-029 rst=0 SHALL immediately and asynchronously clear pixel_x, pixel_y, address, color_addr, color_valid, frame_done, and frame_count to 0, and set color to BG_COLOR.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse, and the first VGA_ready after release SHALL output address 0.
REQ-031 Reset release SHALL be synchronised externally, and the block SHALL act on VGA_ready from the first edge after release.

Verification
REQ-032 Line wrap: hold VGA_ready=1 for 641 cycles from reset -> pixel_x 639 -> 0, pixel_y 0 -> 1, address 640, and color_valid high for all 641 cycles.
REQ-033 Frame wrap: hold VGA_ready=1 for 307200 cycles -> frame_done pulses once on the cycle color_addr=19'h4AFFF, then address=0 and frame_count=1.
REQ-034 Priority and blend: layer0 opaque 0000FF, layer1 opaque FF0000 -> 0000FF; then set layer0 translucent D3D3D3 over FF0000 -> E96969.
REQ-035 Transparent and disabled: all layers at color 0 or mode 2 with BG_COLOR=000000 -> color 000000 and color_valid=1.
REQ-036 Stall and clear: with VGA_ready toggled every other cycle, the position advances only on ready cycles; sync_clear and VGA_ready asserted together at address 1000 -> address 0 and color_valid=0.
REQ-037 Asynchronous reset: assert rst=0 between clock edges at address 5000 -> outputs clear before the next edge, and no frame_done pulse occurs.
